crtc_timing: RTL

//   Raster sequencer for the CRTC: consumes the CPU-programmed register values (R0-R9, R12-R13)
//   and walks the character/scanline/row counters. Produces h_sync, v_sync, display enable and
//   the video memory address (MA) / row address (RA) that fetch character and font data.

---
 rtl/crtc_timing.sv | 134 +++++++++++++
 1 files changed

// File: rtl/crtc_timing.sv
// rtl/crtc_timing.sv - CRTC raster sequencer: character/scanline/row counters, syncs, display enable, MA/RA.
// Each char_strobe emits the current raster position on the outputs, then advances the counters.
module crtc_timing #(
  parameter int MA_WIDTH = 14
) (
  input  logic                clk,
  input  logic                res_b,
  input  logic                char_strobe,
  input  logic [7:0]          r0_h_total,
  input  logic [7:0]          r1_h_displayed,
  input  logic [7:0]          r2_h_sync_pos,
  input  logic [7:0]          r3_sync_width,
  input  logic [6:0]          r4_v_total,
  input  logic [4:0]          r5_v_adjust,
  input  logic [6:0]          r6_v_displayed,
  input  logic [6:0]          r7_v_sync_pos,
  input  logic [4:0]          r9_max_scan,
  input  logic [5:0]          r12_start_hi,
  input  logic [7:0]          r13_start_lo,
  output logic                h_sync,
  output logic                v_sync,
  output logic                de,
  output logic [MA_WIDTH-1:0] ma,
  output logic [4:0]          ra,
  output logic                frame_start
);

  typedef enum logic {ROWS, ADJUST} state_t;

  state_t              state;
  logic [7:0]          h_count;
  logic [4:0]          ra_count;
  logic [6:0]          v_count;
  logic [4:0]          adj_count;
  logic [MA_WIDTH-1:0] ma_row;
  logic                row_init;
  logic [3:0]          hs_rem;
  logic [3:0]          vs_rem;

  logic [MA_WIDTH-1:0] start_addr;
  logic [MA_WIDTH-1:0] ma_base;
  logic                line_end;
  logic                row_end;
  logic                rows_last;
  logic                enter_adj;
  logic                frame_end;

  // row_init stands in for an async load of the live start address, which reset cannot do.
  always_comb begin
    start_addr = MA_WIDTH'({r12_start_hi, r13_start_lo});
    ma_base    = row_init ? start_addr : ma_row;
    line_end   = (h_count == r0_h_total);
    row_end    = line_end && (ra_count == r9_max_scan);
    rows_last  = (state == ROWS) && row_end && (v_count == r4_v_total);
    enter_adj  = rows_last && (r5_v_adjust != 5'd0);
    frame_end  = (rows_last && (r5_v_adjust == 5'd0)) ||
                 ((state == ADJUST) && line_end && (adj_count == r5_v_adjust - 5'd1));
  end

  always_ff @(posedge clk or negedge res_b) begin
    if (!res_b) begin
      state       <= ROWS;
      h_count     <= 8'd0;
      ra_count    <= 5'd0;
      v_count     <= 7'd0;
      adj_count   <= 5'd0;
      ma_row      <= '0;
      row_init    <= 1'b1;
      hs_rem      <= 4'd0;
      vs_rem      <= 4'd0;
      h_sync      <= 1'b0;
      v_sync      <= 1'b0;
      de          <= 1'b0;
      ma          <= '0;
      ra          <= 5'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (char_strobe) begin
        de          <= (h_count < r1_h_displayed) && (v_count < r6_v_displayed) && (state == ROWS);
        ma          <= ma_base + MA_WIDTH'(h_count);
        ra          <= ra_count;
        frame_start <= frame_end;

        // A width field of 0 loads 15 remaining, giving 16 active periods.
        if (h_count == r2_h_sync_pos) begin
          h_sync <= 1'b1;
          hs_rem <= r3_sync_width[3:0] - 4'd1;
        end else if (hs_rem != 4'd0) begin
          hs_rem <= hs_rem - 4'd1;
        end else begin
          h_sync <= 1'b0;
        end

        if (h_count == 8'd0) begin
          if ((state == ROWS) && (v_count == r7_v_sync_pos) && (ra_count == 5'd0)) begin
            v_sync <= 1'b1;
            vs_rem <= r3_sync_width[7:4] - 4'd1;
          end else if (vs_rem != 4'd0) begin
            vs_rem <= vs_rem - 4'd1;
          end else begin
            v_sync <= 1'b0;
          end
        end

        row_init <= 1'b0;
        ma_row   <= ma_base;
        h_count  <= line_end ? 8'd0 : h_count + 8'd1;

        if (frame_end) begin
          state    <= ROWS;
          v_count  <= 7'd0;
          ra_count <= 5'd0;
          ma_row   <= start_addr;
        end else if (line_end) begin
          if (row_end) begin
            ra_count <= 5'd0;
            ma_row   <= ma_base + MA_WIDTH'(r1_h_displayed);
            if ((state == ROWS) && !enter_adj) v_count <= v_count + 7'd1;
          end else begin
            ra_count <= ra_count + 5'd1;
          end
          if (enter_adj) begin
            state     <= ADJUST;
            adj_count <= 5'd0;
          end else if (state == ADJUST) begin
            adj_count <= adj_count + 5'd1;
          end
        end
      end
    end
  end

endmodule
